// File: rtl/debug_frame_sender_pkg.sv
// Shared constants, helper and FSM state type for the debug frame sender.
package debug_frame_sender_pkg;

    localparam int DEF_UART_BITS        = 8;
    localparam int DEF_PROC_BITS        = 32;
    localparam int DEF_CLK_COUNTER_BITS = 32;
    localparam int DEF_RF_REGS_LEN      = 1024;
    localparam int DEF_IF_ID_LEN        = 64;
    localparam int DEF_ID_EX_LEN        = 144;
    localparam int DEF_EX_MEM_LEN       = 80;
    localparam int DEF_MEM_WB_LEN       = 72;
    localparam int DEF_DATA_ADDRS_BITS  = 5;
    localparam int DEF_MEM_WORDS        = 32;
    localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_BYTE,
        ST_TX_WAIT,
        ST_MEM_REQ,
        ST_MEM_LATCH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/debug_frame_sender_byte_field_mux.sv
// Static frame section (SOF, clock count, register file, pipeline latches) as one
// byte-addressable vector; each field zero-padded to whole bytes, LSB first.
module byte_field_mux
    import debug_frame_sender_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int CLK_COUNTER_BITS = DEF_CLK_COUNTER_BITS,
    parameter int RF_REGS_LEN      = DEF_RF_REGS_LEN,
    parameter int IF_ID_LEN        = DEF_IF_ID_LEN,
    parameter int ID_EX_LEN        = DEF_ID_EX_LEN,
    parameter int EX_MEM_LEN       = DEF_EX_MEM_LEN,
    parameter int MEM_WB_LEN       = DEF_MEM_WB_LEN,
    parameter int IDX_W            = 8,
    parameter logic [UART_BITS-1:0] SOF_BYTE = UART_BITS'(DEF_SOF_BYTE)
) (
    input  logic [CLK_COUNTER_BITS-1:0] clk_count,
    input  logic [RF_REGS_LEN-1:0]      rf_regs,
    input  logic [IF_ID_LEN-1:0]        if_id,
    input  logic [ID_EX_LEN-1:0]        id_ex,
    input  logic [EX_MEM_LEN-1:0]       ex_mem,
    input  logic [MEM_WB_LEN-1:0]       mem_wb,
    input  logic [IDX_W-1:0]            byte_idx,
    output logic [UART_BITS-1:0]        byte_data
);

    localparam int CLK_BYTES    = ceil_div(CLK_COUNTER_BITS, UART_BITS);
    localparam int RF_BYTES     = ceil_div(RF_REGS_LEN, UART_BITS);
    localparam int IF_ID_BYTES  = ceil_div(IF_ID_LEN, UART_BITS);
    localparam int ID_EX_BYTES  = ceil_div(ID_EX_LEN, UART_BITS);
    localparam int EX_MEM_BYTES = ceil_div(EX_MEM_LEN, UART_BITS);
    localparam int MEM_WB_BYTES = ceil_div(MEM_WB_LEN, UART_BITS);
    localparam int STATIC_BYTES = 1 + CLK_BYTES + RF_BYTES + IF_ID_BYTES
                                + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;

    logic [STATIC_BYTES*UART_BITS-1:0] frame;

    assign frame = {(MEM_WB_BYTES*UART_BITS)'(mem_wb),
                    (EX_MEM_BYTES*UART_BITS)'(ex_mem),
                    (ID_EX_BYTES*UART_BITS)'(id_ex),
                    (IF_ID_BYTES*UART_BITS)'(if_id),
                    (RF_BYTES*UART_BITS)'(rf_regs),
                    (CLK_BYTES*UART_BITS)'(clk_count),
                    SOF_BYTE};

    // Index past the static section reads as zero (shift, not select).
    assign byte_data = UART_BITS'(frame >> (int'(byte_idx) * UART_BITS));

endmodule

// File: rtl/debug_frame_sender.sv
// Streams one debug snapshot (static fields, then data memory words) to uart_tx.
module debug_frame_sender
    import debug_frame_sender_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int PROC_BITS        = DEF_PROC_BITS,
    parameter int CLK_COUNTER_BITS = DEF_CLK_COUNTER_BITS,
    parameter int RF_REGS_LEN      = DEF_RF_REGS_LEN,
    parameter int IF_ID_LEN        = DEF_IF_ID_LEN,
    parameter int ID_EX_LEN        = DEF_ID_EX_LEN,
    parameter int EX_MEM_LEN       = DEF_EX_MEM_LEN,
    parameter int MEM_WB_LEN       = DEF_MEM_WB_LEN,
    parameter int DATA_ADDRS_BITS  = DEF_DATA_ADDRS_BITS,
    parameter int MEM_WORDS        = DEF_MEM_WORDS,
    parameter logic [UART_BITS-1:0] SOF_BYTE = UART_BITS'(DEF_SOF_BYTE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_tx_done,
    input  logic [CLK_COUNTER_BITS-1:0] i_clk_count,
    input  logic [RF_REGS_LEN-1:0]      i_rf_regs,
    input  logic [IF_ID_LEN-1:0]        i_if_id_signals,
    input  logic [ID_EX_LEN-1:0]        i_id_ex_signals,
    input  logic [EX_MEM_LEN-1:0]       i_ex_mem_signals,
    input  logic [MEM_WB_LEN-1:0]       i_mem_wb_signals,
    input  logic [PROC_BITS-1:0]        i_mem_data,
    output logic                        o_debug_read_data,
    output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address,
    output logic                        o_tx_start,
    output logic [UART_BITS-1:0]        o_tx_data,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int STATIC_BYTES = 1 + ceil_div(CLK_COUNTER_BITS, UART_BITS)
                                + ceil_div(RF_REGS_LEN, UART_BITS)
                                + ceil_div(IF_ID_LEN, UART_BITS)
                                + ceil_div(ID_EX_LEN, UART_BITS)
                                + ceil_div(EX_MEM_LEN, UART_BITS)
                                + ceil_div(MEM_WB_LEN, UART_BITS);
    localparam int WORD_BYTES   = ceil_div(PROC_BITS, UART_BITS);
    localparam int BYTE_IDX_W   = $clog2(STATIC_BYTES);
    localparam int BSEL_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WORD_IDX_W   = DATA_ADDRS_BITS + 1;
    localparam int WBUF_W       = WORD_BYTES * UART_BITS;

    state_t                        state, state_n;
    logic [BYTE_IDX_W-1:0]         byte_idx, byte_idx_n, mux_idx;
    logic [WORD_IDX_W-1:0]         word_idx, word_idx_n;
    logic [BSEL_W-1:0]             bsel, bsel_n, bsel_inc;
    logic                          in_mem, in_mem_n;
    logic [WBUF_W-1:0]             word_buf, word_buf_n;
    logic [CLK_COUNTER_BITS-1:0]   clk_lat, clk_lat_n;
    logic                          tx_start_n;
    logic [UART_BITS-1:0]          tx_data_n, field_byte;

    // Bytes after the first are loaded straight from TX_WAIT / MEM_LATCH into the
    // registered outputs, giving 1-cycle (static) and 3-cycle (word) turnaround.
    assign mux_idx  = (state == ST_LOAD_BYTE) ? byte_idx : byte_idx + BYTE_IDX_W'(1);
    assign bsel_inc = bsel + BSEL_W'(1);

    byte_field_mux #(
        .UART_BITS        (UART_BITS),
        .CLK_COUNTER_BITS (CLK_COUNTER_BITS),
        .RF_REGS_LEN      (RF_REGS_LEN),
        .IF_ID_LEN        (IF_ID_LEN),
        .ID_EX_LEN        (ID_EX_LEN),
        .EX_MEM_LEN       (EX_MEM_LEN),
        .MEM_WB_LEN       (MEM_WB_LEN),
        .IDX_W            (BYTE_IDX_W),
        .SOF_BYTE         (SOF_BYTE)
    ) u_byte_field_mux (
        .clk_count (clk_lat),
        .rf_regs   (i_rf_regs),
        .if_id     (i_if_id_signals),
        .id_ex     (i_id_ex_signals),
        .ex_mem    (i_ex_mem_signals),
        .mem_wb    (i_mem_wb_signals),
        .byte_idx  (mux_idx),
        .byte_data (field_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_idx   <= '0;
            word_idx   <= '0;
            bsel       <= '0;
            in_mem     <= 1'b0;
            word_buf   <= '0;
            clk_lat    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            state      <= state_n;
            byte_idx   <= byte_idx_n;
            word_idx   <= word_idx_n;
            bsel       <= bsel_n;
            in_mem     <= in_mem_n;
            word_buf   <= word_buf_n;
            clk_lat    <= clk_lat_n;
            o_tx_start <= tx_start_n;
            o_tx_data  <= tx_data_n;
        end
    end

    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        word_idx_n = word_idx;
        bsel_n     = bsel;
        in_mem_n   = in_mem;
        word_buf_n = word_buf;
        clk_lat_n  = clk_lat;
        tx_start_n = 1'b0;
        tx_data_n  = o_tx_data;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_n    = ST_LOAD_BYTE;
                    byte_idx_n = '0;
                    word_idx_n = '0;
                    bsel_n     = '0;
                    in_mem_n   = 1'b0;
                    clk_lat_n  = i_clk_count;
                end
            end
            ST_LOAD_BYTE: begin
                tx_start_n = 1'b1;
                tx_data_n  = field_byte;
                state_n    = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (i_tx_done) begin
                    if (!in_mem) begin
                        if (byte_idx == BYTE_IDX_W'(STATIC_BYTES - 1)) begin
                            in_mem_n = 1'b1;
                            state_n  = (MEM_WORDS > 0) ? ST_MEM_REQ : ST_DONE;
                        end else begin
                            byte_idx_n = mux_idx;
                            tx_start_n = 1'b1;
                            tx_data_n  = field_byte;
                        end
                    end else if (bsel == BSEL_W'(WORD_BYTES - 1)) begin
                        if (word_idx == WORD_IDX_W'(MEM_WORDS - 1)) begin
                            state_n = ST_DONE;
                        end else begin
                            word_idx_n = word_idx + WORD_IDX_W'(1);
                            state_n    = ST_MEM_REQ;
                        end
                    end else begin
                        bsel_n     = bsel_inc;
                        tx_start_n = 1'b1;
                        tx_data_n  = UART_BITS'(word_buf >> (int'(bsel_inc) * UART_BITS));
                    end
                end
            end
            ST_MEM_REQ: begin
                state_n = ST_MEM_LATCH;
            end
            ST_MEM_LATCH: begin
                word_buf_n = WBUF_W'(i_mem_data);
                bsel_n     = '0;
                tx_start_n = 1'b1;
                tx_data_n  = i_mem_data[UART_BITS-1:0];
                state_n    = ST_TX_WAIT;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign o_debug_read_data    = (state == ST_MEM_REQ) || (state == ST_MEM_LATCH);
    assign o_debug_read_address = o_debug_read_data ? word_idx[DATA_ADDRS_BITS-1:0] : '0;
    assign o_busy               = (state != ST_IDLE) && (state != ST_DONE);
    assign o_done               = (state == ST_DONE);

endmodule
